// File: rtl/multdiv_controller_if.sv
// Start/operand/result bundle between the pipeline and the
// iterative multiply/divide sequencer.
interface multdiv_controller_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT,
    output ctrl_DIV,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  ctrl_MULT,
    input  ctrl_DIV,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );
endinterface

// File: rtl/multdiv_controller.sv
// Iterative 32-cycle sequencer: radix-2 Booth multiply and
// restoring signed divide sharing one 65-bit working register.
module multdiv_controller #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 clr,
  multdiv_controller_if.slave  md
);
  localparam int RW = 2*WIDTH+1;

  typedef enum logic [1:0] {
    IDLE, MULT, DIV, DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RW-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   m_q;
  logic             neg_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q;
  logic             busy_q;

  logic [WIDTH:0]   up, sum, diff;
  logic [RW-1:0]    shl;
  logic [WIDTH-1:0] abs_a, abs_b, quo;
  logic             div0, fin;

  assign abs_a = md.data_operandA[WIDTH-1]
               ? -md.data_operandA : md.data_operandA;
  assign abs_b = md.data_operandB[WIDTH-1]
               ? -md.data_operandB : md.data_operandB;

  assign div0 = (state_q == DIV) && (m_q == '0);
  assign fin  = (cnt_q == CNT_W'(WIDTH)) || div0;

  always_comb begin
    // Booth step on a 33-bit upper half so B=INT_MIN cannot overflow
    up  = {acc_q[RW-1], acc_q[RW-1:WIDTH+1]};
    sum = up;
    unique case (acc_q[1:0])
      2'b01:   sum = up + m_q;
      2'b10:   sum = up - m_q;
      default: sum = up;
    endcase
    shl  = {acc_q[RW-2:0], 1'b0};
    diff = shl[RW-1:WIDTH] - m_q;
    quo  = acc_q[WIDTH-1:0];

    acc_d = acc_q;
    res_d = '0;
    exc_d = 1'b0;
    if (state_q == MULT) begin
      acc_d = {sum, acc_q[WIDTH:1]};
      res_d = acc_q[WIDTH:1];
      exc_d = acc_q[RW-1:WIDTH+1] != {WIDTH{acc_q[WIDTH]}};
    end else begin
      acc_d = diff[WIDTH] ? shl
            : {diff, shl[WIDTH-1:1], 1'b1};
      if (div0) begin
        res_d = '0;
        exc_d = 1'b1;
      end else begin
        res_d = neg_q ? -quo : quo;
        // only |INT_MIN / -1| yields a positive quotient with bit 31 set
        exc_d = ~neg_q & quo[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (md.ctrl_MULT) begin
        state_q <= MULT;
        cnt_q   <= '0;
        acc_q   <= {{WIDTH{1'b0}}, md.data_operandA, 1'b0};
        m_q     <= {md.data_operandB[WIDTH-1], md.data_operandB};
        neg_q   <= 1'b0;
        busy_q  <= 1'b1;
      end else if (md.ctrl_DIV) begin
        state_q <= DIV;
        cnt_q   <= '0;
        acc_q   <= {{(WIDTH+1){1'b0}}, abs_a};
        m_q     <= {1'b0, abs_b};
        neg_q   <= md.data_operandA[WIDTH-1]
                 ^ md.data_operandB[WIDTH-1];
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          MULT, DIV: begin
            if (fin) begin
              state_q <= DONE;
              res_q   <= res_d;
              exc_q   <= exc_d;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign md.data_result    = res_q;
  assign md.data_exception = exc_q;
  assign md.data_resultRDY = rdy_q;
  assign md.busy           = busy_q;
endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller: latency, results,
// exceptions, abort, simultaneous starts and clear.
module tb_multdiv_controller;
  logic clk;
  logic clr;
  int   n_chk;
  int   n_fail;
  logic [31:0] prev_res;

  multdiv_controller_if #(.WIDTH(32)) md ();

  multdiv_controller #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .clr (clr),
    .md  (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // returns sampled one time unit after the start edge N
  task automatic pulse(input logic m, input logic d,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    md.ctrl_MULT     = m;
    md.ctrl_DIV      = d;
    md.data_operandA = a;
    md.data_operandB = b;
    @(posedge clk);
    #1;
    md.ctrl_MULT = 1'b0;
    md.ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_rdy(output int lat, output int bcnt);
    lat  = -1;
    bcnt = int'(md.busy);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (md.data_resultRDY) begin
        lat = k;
        break;
      end
      bcnt += int'(md.busy);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic m, input logic d,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp_res,
                        input logic exp_exc,
                        input int exp_lat);
    int lat, bcnt;
    pulse(m, d, a, b);
    chk({tag, "_hold"}, md.data_result, prev_res);
    wait_rdy(lat, bcnt);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, bcnt, exp_lat);
    chk({tag, "_res"}, md.data_result, exp_res);
    chk({tag, "_exc"}, {31'b0, md.data_exception},
        {31'b0, exp_exc});
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'b0, md.data_resultRDY}, 32'h0);
    prev_res = exp_res;
  endtask

  initial begin
    int lat, bcnt;
    logic seen_rdy, seen_busy;
    n_chk  = 0;
    n_fail = 0;
    prev_res = 32'h0;
    md.ctrl_MULT     = 1'b0;
    md.ctrl_DIV      = 1'b0;
    md.data_operandA = '0;
    md.data_operandB = '0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", md.data_result, 32'h0);
    chk("rst_exc", {31'b0, md.data_exception}, 32'h0);
    chk("rst_rdy", {31'b0, md.data_resultRDY}, 32'h0);
    chk("rst_busy", {31'b0, md.busy}, 32'h0);
    @(negedge clk);
    clr = 1'b0;

    run_op("mul_7x-3", 1, 0, 32'd7, 32'hFFFFFFFD,
           32'hFFFFFFEB, 0, 33);
    run_op("mul_ovf", 1, 0, 32'h00010000, 32'h00010000,
           32'h0, 1, 33);
    run_op("mul_m1m1", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h1, 0, 33);
    run_op("mul_minmin", 1, 0, 32'h80000000, 32'h80000000,
           32'h0, 1, 33);
    run_op("div_-7/2", 0, 1, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFD, 0, 33);
    run_op("div_100/-7", 0, 1, 32'd100, 32'hFFFFFFF9,
           32'hFFFFFFF2, 0, 33);
    run_op("div_by0", 0, 1, 32'd5, 32'h0,
           32'h0, 1, 1);
    run_op("div_ovf", 0, 1, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 1, 33);
    run_op("both", 1, 1, 32'd6, 32'd7,
           32'd42, 0, 33);

    // abort: divide started at edge N+10 of a multiply
    pulse(1, 0, 32'd3, 32'd4);
    seen_rdy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      seen_rdy |= md.data_resultRDY;
    end
    pulse(0, 1, 32'd9, 32'd3);
    wait_rdy(lat, bcnt);
    chk("abort_early_rdy", {31'b0, seen_rdy}, 32'h0);
    chk("abort_lat", lat, 33);
    chk("abort_res", md.data_result, 32'd3);
    chk("abort_exc", {31'b0, md.data_exception}, 32'h0);

    // clear at edge N+15 of a multiply, with a start alongside
    pulse(1, 0, 32'd7, 32'hFFFFFFFD);
    repeat (14) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    md.ctrl_DIV      = 1'b1;
    md.data_operandA = 32'd5;
    md.data_operandB = 32'h0;
    @(posedge clk);
    #1;
    chk("clr_res", md.data_result, 32'h0);
    chk("clr_exc", {31'b0, md.data_exception}, 32'h0);
    chk("clr_rdy", {31'b0, md.data_resultRDY}, 32'h0);
    chk("clr_busy", {31'b0, md.busy}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    md.ctrl_DIV = 1'b0;
    seen_rdy  = 1'b0;
    seen_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      seen_rdy  |= md.data_resultRDY;
      seen_busy |= md.busy;
    end
    chk("clr_no_rdy", {31'b0, seen_rdy}, 32'h0);
    chk("clr_no_busy", {31'b0, seen_busy}, 32'h0);
    chk("clr_res_hold", md.data_result, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
